stage_5_byte_packer: RTL and testbench
======================================

Name: stage_5_byte_packer

Overview:
- Downstream neighbour of the carry-propagation stage (stage 4).
- Each cycle it takes 0–5 resolved bitstream bytes plus the stage-4 last flag, and writes them into a circular byte buffer in order.
- It drains the buffer as a single-byte valid/ready stream toward the memory/AXI writer, and marks the final byte of the frame.
- Stage 4 has no stall input, so the block exports occupancy, almost-full and sticky error flags instead of backpressuring upstream.

Parameters:
- S5_BITSTREAM_WIDTH, 8, width of each byte lane and of the output byte
- S5_DEPTH, 16, buffer depth in bytes; power of two, at least 8
- S5_PTR_WIDTH, 4, log2(S5_DEPTH); read/write pointer width
- S5_OCC_WIDTH, 5, log2(S5_DEPTH)+1; occupancy counter width

Ports:
- s5_clk  input  1  clock; all state on rising edge
- s5_reset  input  1  asynchronous active-high reset
- s5_flag_first  input  1  one-cycle pulse: a new frame starts; leaves DONE
- in_carry_bit_1..in_carry_bit_5  input  S5_BITSTREAM_WIDTH each  byte lanes; bit_1 is oldest
- in_carry_flag  input  3  number of valid lanes (0–5), taken from bit_1 upward
- in_flag_last  input  1  the current group is the frame's final group
- out_byte  output  S5_BITSTREAM_WIDTH  byte at the buffer head
- out_valid  output  1  out_byte is valid
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready
- out_last  output  1  out_byte is the frame's final byte (qualified by out_valid)
- out_done  output  1  frame fully drained; held high until restart
- out_occupancy  output  S5_OCC_WIDTH  bytes currently stored
- out_almost_full  output  1  free space below 5 bytes
- out_err_overflow  output  1  sticky: a group was dropped for lack of space
- out_err_protocol  output  1  sticky: illegal flag value, or data after last

Behaviour:
- Reset, asynchronous: pointers = 0, occupancy = 0, state = IDLE, last_pending = 0, last_ptr = 0, both error flags = 0. Outputs follow: out_valid = 0, out_last = 0, out_done = 0, out_almost_full = 0.
- Memory contents are not reset. out_byte is don't-care while out_valid = 0.
- Definitions:
  - n = in_carry_flag when it is 0–5. Values 6 or 7 give n = 0 and set out_err_protocol.
  - free = S5_DEPTH − occupancy, taken at the start of the cycle.
  - pop = out_valid && out_ready.
- Write rule:
  - The group is accepted only if state is IDLE or ACTIVE and n ≤ free. A pop in the same cycle does not add to free.
  - On accept, lane k (k = 1..n) is written to mem[wr_ptr+k−1], modulo S5_DEPTH, and wr_ptr advances by n with wrap.
  - If n > free, the whole group is dropped; nothing is written partially, and out_err_overflow is set.
- Read:
  - out_byte = mem[rd_ptr]; out_valid = (occupancy ≠ 0).
  - On pop, rd_ptr advances by 1 with wrap.
  - A byte written on edge t is visible on the output after edge t, so latency is 1 cycle.
- Occupancy:
  - Next occupancy = occupancy + (accepted ? n : 0) − pop, computed at S5_OCC_WIDTH bits.
  - Simultaneous write and pop are legal.
  - out_almost_full = (free < 5), combinational from occupancy.
- State machine (2-bit state):
  - IDLE → ACTIVE on the first accepted group with n > 0.
  - IDLE or ACTIVE → DRAIN when in_flag_last is high on a cycle whose group is accepted, including n = 0. Then last_pending = 1 and last_ptr = wr_ptr + n − 1.
  - If in_flag_last arrives with n = 0 and occupancy = 0, the state goes directly to DONE.
  - DRAIN → DONE on the pop of the byte at last_ptr.
  - DONE → IDLE on s5_flag_first.
  - s5_flag_first seen in IDLE, ACTIVE or DRAIN is ignored.
- Last and done:
  - out_last = last_pending && (rd_ptr == last_ptr) && (occupancy ≠ 0).
  - out_done = 1 exactly while state is DONE.
- In DRAIN or DONE:
  - Groups with n > 0 are dropped and set out_err_protocol.
  - Groups with n = 0 are ignored silently.
- Error flags are cleared only by s5_reset.
- Reset asserted mid-frame discards all buffered bytes immediately, without waiting for a clock edge.

Test Plan:
- Reset, then three groups {flag=2: 0xA1,0xA2}, {flag=0}, {flag=3: 0xB1,0xB2,0xB3}, with out_ready held at 1. Required: output sequence A1,A2,B1,B2,B3; out_valid rises 1 cycle after the first write; occupancy peaks at 3 and ends at 0.
- out_ready = 0 while driving flag=5 for 3 cycles into a 16-byte buffer. Required: occupancy goes 5, 10, 15; the third cycle leaves free = 1 < 5, so out_almost_full = 1. A fourth flag=5 group sets out_err_overflow and occupancy stays 15. Releasing out_ready then yields exactly 15 bytes in input order.
- Wrap-around: fill 14 bytes, drain 14, then write flag=5 (0xC0–0xC4). Required: wr_ptr wraps 14 → 3; the bytes emerge as C0–C4; occupancy = 5.
- Simultaneous write and pop at occupancy 16: write flag=1. Required: the group is dropped and overflow is set, because free is counted before the pop. Occupancy becomes 15.
- Frame end: group flag=2 {0xD1,0xD2} with in_flag_last = 1, out_ready = 1. Required: out_last = 1 only with 0xD2; out_done = 1 the cycle after that pop. A later flag=1 sets out_err_protocol. s5_flag_first returns the state to IDLE with out_done = 0.
- Edge cases: flag = 7 sets out_err_protocol and writes nothing. in_flag_last with flag = 0 on an empty buffer gives out_done = 1 next cycle with out_last never asserted. Asserting s5_reset mid-frame drops out_valid to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/stage_5_byte_packer.sv
// Stage 5 byte packer: collects 0..5 resolved bytes per cycle from stage 4
// into a circular buffer and drains them as a single-byte valid/ready stream.
// Stage 4 cannot be stalled. The block therefore reports occupancy,
// almost-full and sticky error flags instead of applying backpressure.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the first non-empty group of a frame
// ACTIVE  | frame in progress, groups accepted while space allows
// DRAIN   | last group seen, emptying buffer up to the byte at last_ptr
// DONE    | frame fully drained, waiting for s5_flag_first
module stage_5_byte_packer #(
  parameter int S5_BITSTREAM_WIDTH = 8,
  parameter int S5_DEPTH           = 16,
  parameter int S5_PTR_WIDTH       = 4,
  parameter int S5_OCC_WIDTH       = 5
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset,
  input  logic                          s5_flag_first,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
  input  logic [2:0]                    in_carry_flag,
  input  logic                          in_flag_last,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_done,
  output logic [S5_OCC_WIDTH-1:0]       out_occupancy,
  output logic                          out_almost_full,
  output logic                          out_err_overflow,
  output logic                          out_err_protocol
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [S5_OCC_WIDTH-1:0] DEPTH_OCC = S5_OCC_WIDTH'(S5_DEPTH);
  localparam logic [S5_OCC_WIDTH-1:0] AF_LIMIT  = S5_OCC_WIDTH'(5);

  state_t                          state_q, state_d;
  logic [S5_PTR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [S5_PTR_WIDTH-1:0]         rd_ptr_q, rd_ptr_d;
  logic [S5_PTR_WIDTH-1:0]         last_ptr_q, last_ptr_d;
  logic [S5_OCC_WIDTH-1:0]         occ_q, occ_d;
  logic                            last_pending_q, last_pending_d;
  logic                            err_ovf_q, err_ovf_d;
  logic                            err_prot_q, err_prot_d;

  logic [S5_BITSTREAM_WIDTH-1:0]   mem_q [S5_DEPTH];
  logic [S5_BITSTREAM_WIDTH-1:0]   lane [5];

  logic                            flag_legal;
  logic [2:0]                      n;
  logic [S5_OCC_WIDTH-1:0]         n_occ;
  logic [S5_PTR_WIDTH-1:0]         n_ptr;
  logic [S5_OCC_WIDTH-1:0]         free;
  logic                            open;
  logic                            accept;
  logic                            drop_ovf;
  logic                            pop;

  assign lane[0] = in_carry_bit_1;
  assign lane[1] = in_carry_bit_2;
  assign lane[2] = in_carry_bit_3;
  assign lane[3] = in_carry_bit_4;
  assign lane[4] = in_carry_bit_5;

  // Illegal lane counts (6, 7) are treated as an empty group.
  assign flag_legal = (in_carry_flag <= 3'd5);
  assign n          = flag_legal ? in_carry_flag : 3'd0;
  assign n_occ      = S5_OCC_WIDTH'(n);
  assign n_ptr      = S5_PTR_WIDTH'(n);

  // Free space is taken before any pop in the same cycle, so a full buffer
  // rejects a group even while it is emitting a byte.
  assign free     = DEPTH_OCC - occ_q;
  assign open     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign accept   = open && (n_occ <= free);
  assign drop_ovf = open && (n_occ > free);
  assign pop      = out_valid && out_ready;

  assign out_byte         = mem_q[rd_ptr_q];
  assign out_valid        = (occ_q != '0);
  assign out_last         = last_pending_q && (rd_ptr_q == last_ptr_q) && out_valid;
  assign out_done         = (state_q == ST_DONE);
  assign out_occupancy    = occ_q;
  assign out_almost_full  = (free < AF_LIMIT);
  assign out_err_overflow = err_ovf_q;
  assign out_err_protocol = err_prot_q;

  // Next-state for pointers, occupancy, error flags and the frame FSM.
  always_comb begin
    state_d        = state_q;
    last_pending_d = last_pending_q;
    last_ptr_d     = last_ptr_q;
    wr_ptr_d       = accept ? (wr_ptr_q + n_ptr) : wr_ptr_q;
    rd_ptr_d       = pop ? (rd_ptr_q + S5_PTR_WIDTH'(1)) : rd_ptr_q;
    occ_d          = occ_q + (accept ? n_occ : '0) - (pop ? S5_OCC_WIDTH'(1) : '0);
    err_ovf_d      = err_ovf_q | drop_ovf;
    err_prot_d     = err_prot_q | ~flag_legal | (~open & (n != 3'd0));

    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (accept && in_flag_last) begin
          // Nothing left to emit: the frame is already complete.
          if (occ_d == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d        = ST_DRAIN;
            last_pending_d = 1'b1;
            last_ptr_d     = wr_ptr_q + n_ptr - S5_PTR_WIDTH'(1);
          end
        end else if (accept && (n != 3'd0)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (pop && (rd_ptr_q == last_ptr_q)) begin
          state_d        = ST_DONE;
          last_pending_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (s5_flag_first) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers; reset empties the buffer immediately.
  always_ff @(posedge s5_clk or posedge s5_reset) begin
    if (s5_reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      last_ptr_q     <= '0;
      occ_q          <= '0;
      last_pending_q <= 1'b0;
      err_ovf_q      <= 1'b0;
      err_prot_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      last_ptr_q     <= last_ptr_d;
      occ_q          <= occ_d;
      last_pending_q <= last_pending_d;
      err_ovf_q      <= err_ovf_d;
      err_prot_q     <= err_prot_d;
    end
  end

  // Byte storage: write lanes 1..n at consecutive wrapped addresses.
  always_ff @(posedge s5_clk) begin
    for (int k = 0; k < 5; k++) begin
      if (accept && (3'(k) < n)) begin
        mem_q[wr_ptr_q + S5_PTR_WIDTH'(k)] <= lane[k];
      end
    end
  end

endmodule

// File: tb/tb_stage_5_byte_packer.sv
// Bench for stage_5_byte_packer: directed groups with hand-computed
// expected bytes pushed to a scoreboard queue; a monitor checks every pop.
module tb_stage_5_byte_packer;

  logic       s5_clk = 1'b0;
  logic       s5_reset = 1'b1;
  logic       s5_flag_first = 1'b0;
  logic [7:0] in_carry_bit_1 = '0;
  logic [7:0] in_carry_bit_2 = '0;
  logic [7:0] in_carry_bit_3 = '0;
  logic [7:0] in_carry_bit_4 = '0;
  logic [7:0] in_carry_bit_5 = '0;
  logic [2:0] in_carry_flag = '0;
  logic       in_flag_last = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       out_done;
  logic [4:0] out_occupancy;
  logic       out_almost_full;
  logic       out_err_overflow;
  logic       out_err_protocol;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  stage_5_byte_packer dut (
    .s5_clk           (s5_clk),
    .s5_reset         (s5_reset),
    .s5_flag_first    (s5_flag_first),
    .in_carry_bit_1   (in_carry_bit_1),
    .in_carry_bit_2   (in_carry_bit_2),
    .in_carry_bit_3   (in_carry_bit_3),
    .in_carry_bit_4   (in_carry_bit_4),
    .in_carry_bit_5   (in_carry_bit_5),
    .in_carry_flag    (in_carry_flag),
    .in_flag_last     (in_flag_last),
    .out_byte         (out_byte),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .out_done         (out_done),
    .out_occupancy    (out_occupancy),
    .out_almost_full  (out_almost_full),
    .out_err_overflow (out_err_overflow),
    .out_err_protocol (out_err_protocol)
  );

  always #5 s5_clk = ~s5_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge s5_clk);
    #1;
  endtask

  // Present one group for one clock edge, then return the inputs to idle.
  task automatic grp(input logic [2:0] flag, input logic [7:0] base, input logic last);
    in_carry_flag  = flag;
    in_carry_bit_1 = base;
    in_carry_bit_2 = base + 8'd1;
    in_carry_bit_3 = base + 8'd2;
    in_carry_bit_4 = base + 8'd3;
    in_carry_bit_5 = base + 8'd4;
    in_flag_last   = last;
    tick();
    in_carry_flag  = 3'd0;
    in_flag_last   = 1'b0;
  endtask

  task automatic push(input logic [7:0] base, input int cnt, input logic last);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({last && (i == cnt - 1), base + 8'(i)});
    end
  endtask

  task automatic reset_pulse();
    s5_reset = 1'b1;
    tick();
    s5_reset = 1'b0;
  endtask

  task automatic pulse_first();
    s5_flag_first = 1'b1;
    tick();
    s5_flag_first = 1'b0;
  endtask

  // Scoreboard monitor: a pop happens on the next rising edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge s5_clk);
      if (!s5_reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, expected none", out_byte);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", 32'(out_byte), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    s5_reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_done", 32'(out_done), 0);
    chk("rst_occ", 32'(out_occupancy), 0);
    chk("rst_af", 32'(out_almost_full), 0);
    chk("rst_ovf", 32'(out_err_overflow), 0);
    chk("rst_prot", 32'(out_err_protocol), 0);

    // Basic ordering with out_ready held high
    push(8'hA1, 2, 1'b0);
    push(8'hB1, 3, 1'b0);
    grp(3'd2, 8'hA1, 1'b0);
    chk("t1_valid_rise", 32'(out_valid), 1);
    chk("t1_occ2", 32'(out_occupancy), 2);
    grp(3'd0, 8'h00, 1'b0);
    chk("t1_occ1", 32'(out_occupancy), 1);
    grp(3'd3, 8'hB1, 1'b0);
    chk("t1_occ_peak", 32'(out_occupancy), 3);
    tick(); tick(); tick();
    chk("t1_occ_end", 32'(out_occupancy), 0);

    // Fill without draining, then overflow
    out_ready = 1'b0;
    push(8'h10, 15, 1'b0);
    grp(3'd5, 8'h10, 1'b0);
    chk("t2_occ5", 32'(out_occupancy), 5);
    chk("t2_af_5", 32'(out_almost_full), 0);
    grp(3'd5, 8'h15, 1'b0);
    chk("t2_occ10", 32'(out_occupancy), 10);
    chk("t2_af_10", 32'(out_almost_full), 0);
    grp(3'd5, 8'h1A, 1'b0);
    chk("t2_occ15", 32'(out_occupancy), 15);
    chk("t2_af_15", 32'(out_almost_full), 1);
    chk("t2_ovf_pre", 32'(out_err_overflow), 0);
    grp(3'd5, 8'h20, 1'b0);
    chk("t2_occ_hold", 32'(out_occupancy), 15);
    chk("t2_ovf", 32'(out_err_overflow), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("t2_occ_end", 32'(out_occupancy), 0);
    chk("t2_ovf_sticky", 32'(out_err_overflow), 1);

    // Wrap-around from pointer 14, then simultaneous write and pop when full
    out_ready = 1'b0;
    reset_pulse();
    chk("t3_ovf_clr", 32'(out_err_overflow), 0);
    push(8'h40, 14, 1'b0);
    grp(3'd5, 8'h40, 1'b0);
    grp(3'd5, 8'h45, 1'b0);
    grp(3'd4, 8'h4A, 1'b0);
    chk("t3_occ14", 32'(out_occupancy), 14);
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    out_ready = 1'b0;
    chk("t3_occ0", 32'(out_occupancy), 0);
    push(8'hC0, 5, 1'b0);
    grp(3'd5, 8'hC0, 1'b0);
    chk("t3_wrap_occ5", 32'(out_occupancy), 5);
    push(8'h60, 11, 1'b0);
    grp(3'd5, 8'h60, 1'b0);
    grp(3'd5, 8'h65, 1'b0);
    grp(3'd1, 8'h6A, 1'b0);
    chk("t4_occ16", 32'(out_occupancy), 16);
    chk("t4_af", 32'(out_almost_full), 1);
    chk("t4_ovf_pre", 32'(out_err_overflow), 0);
    out_ready = 1'b1;
    grp(3'd1, 8'hEE, 1'b0);
    chk("t4_occ15", 32'(out_occupancy), 15);
    chk("t4_ovf", 32'(out_err_overflow), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_occ_end", 32'(out_occupancy), 0);

    // Frame end
    chk("t5_prot_pre", 32'(out_err_protocol), 0);
    push(8'hD1, 2, 1'b1);
    grp(3'd2, 8'hD1, 1'b1);
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_last_d1", 32'(out_last), 0);
    tick();
    chk("t5_last_d2", 32'(out_last), 1);
    chk("t5_done_early", 32'(out_done), 0);
    tick();
    chk("t5_done", 32'(out_done), 1);
    chk("t5_valid_end", 32'(out_valid), 0);
    grp(3'd1, 8'h55, 1'b0);
    chk("t5_prot", 32'(out_err_protocol), 1);
    chk("t5_occ_drop", 32'(out_occupancy), 0);
    chk("t5_done_hold", 32'(out_done), 1);
    pulse_first();
    chk("t5_restart", 32'(out_done), 0);

    // Edge cases
    reset_pulse();
    chk("t6_prot_clr", 32'(out_err_protocol), 0);
    grp(3'd7, 8'h70, 1'b0);
    chk("t6_prot7", 32'(out_err_protocol), 1);
    chk("t6_occ7", 32'(out_occupancy), 0);
    chk("t6_valid7", 32'(out_valid), 0);
    grp(3'd0, 8'h00, 1'b1);
    chk("t6_done_empty", 32'(out_done), 1);
    chk("t6_last_never", 32'(out_last), 0);
    pulse_first();
    chk("t6_restart", 32'(out_done), 0);
    out_ready = 1'b0;
    grp(3'd3, 8'h80, 1'b0);
    chk("t6_occ3", 32'(out_occupancy), 3);
    chk("t6_valid3", 32'(out_valid), 1);
    #2;
    s5_reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_occ", 32'(out_occupancy), 0);
    tick();
    s5_reset = 1'b0;
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
